// File: rtl/base_or_pipe_pkg.sv
// Elaboration-time sizing helpers for the registered OR-reduction tree.
package base_or_pipe_pkg;

  // Number of tree levels needed to reduce `ways` leaves with fan-in `radix`.
  function automatic int tree_levels(input int ways, input int radix);
    int n;
    int lv;
    n  = ways;
    lv = 0;
    while (n > 1) begin
      n  = (n + radix - 1) / radix;
      lv = lv + 1;
    end
    return lv;
  endfunction

  // Node count at level k: ceil(ways / radix^k), computed by repeated ceiling division.
  function automatic int tree_nodes(input int ways, input int radix, input int k);
    int n;
    n = ways;
    for (int i = 0; i < k; i++) begin
      n = (n + radix - 1) / radix;
    end
    return n;
  endfunction

endpackage

// File: rtl/base_or_stage.sv
// One tree level: OR each group of up to `radix` inputs, then register data and valid under en.
module base_or_stage #(
  parameter int width = 1,
  parameter int n_in  = 1,
  parameter int n_out = 1,
  parameter int radix = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     in_v,
  input  logic [0:n_in*width-1]    in_d,
  output logic                     out_v,
  output logic [0:n_out*width-1]   out_d
);

  logic [0:n_out*width-1] grp;
  logic [0:n_out*width-1] data_d;
  logic [0:n_out*width-1] data_q;
  logic                   v_d;
  logic                   v_q;

  for (genvar gn = 0; gn < n_out; gn++) begin : g_node
    localparam int FIRST = gn * radix;
    // The last group may be partial; only inputs that exist are ORed.
    localparam int CNT = ((n_in - FIRST) < radix) ? (n_in - FIRST) : radix;
    logic [0:width-1] acc;

    always_comb begin
      acc = '0;
      for (int r = 0; r < CNT; r++) begin
        acc = acc | in_d[(FIRST + r) * width +: width];
      end
    end

    assign grp[gn * width +: width] = acc;
  end

  always_comb begin
    data_d = en ? grp : data_q;
    v_d    = en ? in_v : v_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      v_q    <= 1'b0;
    end else begin
      data_q <= data_d;
      v_q    <= v_d;
    end
  end

  assign out_d = data_q;
  assign out_v = v_q;

endmodule

// File: rtl/base_or_pipe.sv
// Pipelined, globally stalled OR reduction of `ways` lanes with a sticky accumulator of
// every delivered result.
module base_or_pipe
  import base_or_pipe_pkg::*;
#(
  parameter int width = 1,
  parameter int ways  = 1,
  parameter int radix = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_v,
  output logic                  o_r,
  input  logic [0:ways*width-1] i_d,
  output logic                  o_v,
  input  logic                  i_r,
  output logic [0:width-1]      o_d,
  input  logic                  i_clr,
  output logic [0:width-1]      o_s
);

  localparam int LEVELS = tree_levels(ways, radix);
  // A single lane still gets one register stage so latency is never zero.
  localparam int LAT    = (LEVELS < 1) ? 1 : LEVELS;

  logic             en;
  logic [0:width-1] s_d;
  logic [0:width-1] s_q;

  assign en  = ~o_v | i_r;
  assign o_r = en;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    localparam int N_IN  = tree_nodes(ways, radix, k);
    localparam int N_OUT = tree_nodes(ways, radix, k + 1);
    logic [0:N_OUT*width-1] lvl_data;
    logic                   lvl_v;

    if (k == 0) begin : g_first
      base_or_stage #(
        .width (width),
        .n_in  (N_IN),
        .n_out (N_OUT),
        .radix (radix)
      ) u_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .in_v    (i_v),
        .in_d    (i_d),
        .out_v   (lvl_v),
        .out_d   (lvl_data)
      );
    end else begin : g_next
      base_or_stage #(
        .width (width),
        .n_in  (N_IN),
        .n_out (N_OUT),
        .radix (radix)
      ) u_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .in_v    (g_stage[k-1].lvl_v),
        .in_d    (g_stage[k-1].lvl_data),
        .out_v   (lvl_v),
        .out_d   (lvl_data)
      );
    end
  end

  assign o_v = g_stage[LAT-1].lvl_v;
  assign o_d = g_stage[LAT-1].lvl_data;

  // A clear coinciding with a delivery keeps exactly that delivery.
  always_comb begin
    s_d = (i_clr ? '0 : s_q) | ((o_v & i_r) ? o_d : '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign o_s = s_q;

endmodule

// File: tb/tb_base_or_pipe.sv
// Directed bench for base_or_pipe across three tree shapes: 16x8 radix 4, 5x8 radix 2, 1x4.
module tb_base_or_pipe;

  logic clk;
  logic reset_n;

  logic         a_i_v, a_o_r, a_o_v, a_i_r, a_i_clr;
  logic [0:127] a_i_d;
  logic [0:7]   a_o_d, a_o_s;

  logic         b_i_v, b_o_r, b_o_v, b_i_r, b_i_clr;
  logic [0:39]  b_i_d;
  logic [0:7]   b_o_d, b_o_s;

  logic         c_i_v, c_o_r, c_o_v, c_i_r, c_i_clr;
  logic [0:3]   c_i_d;
  logic [0:3]   c_o_d, c_o_s;

  int checks = 0;
  int errors = 0;

  base_or_pipe #(.width(8), .ways(16), .radix(4)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .i_v(a_i_v), .o_r(a_o_r), .i_d(a_i_d),
    .o_v(a_o_v), .i_r(a_i_r), .o_d(a_o_d), .i_clr(a_i_clr), .o_s(a_o_s)
  );

  base_or_pipe #(.width(8), .ways(5), .radix(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .i_v(b_i_v), .o_r(b_o_r), .i_d(b_i_d),
    .o_v(b_o_v), .i_r(b_i_r), .o_d(b_o_d), .i_clr(b_i_clr), .o_s(b_o_s)
  );

  base_or_pipe #(.width(4), .ways(1), .radix(4)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .i_v(c_i_v), .o_r(c_o_r), .i_d(c_i_d),
    .o_v(c_o_v), .i_r(c_i_r), .o_d(c_o_d), .i_clr(c_i_clr), .o_s(c_o_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // Stream vectors: two non-zero lanes per input, expected OR worked out by hand.
  int         la [10] = '{0, 3, 15, 7, 1, 9, 2, 14, 11, 5};
  int         lb [10] = '{15, 4, 0, 8, 2, 10, 13, 6, 12, 0};
  logic [7:0] xa [10] = '{8'h01, 8'h10, 8'h80, 8'h0F, 8'h00, 8'h55, 8'h81, 8'h3C, 8'h20, 8'hC0};
  logic [7:0] xb [10] = '{8'h02, 8'h10, 8'h40, 8'hF0, 8'h00, 8'h22, 8'h18, 8'h03, 8'h04, 8'h06};
  logic [7:0] ex [10] = '{8'h03, 8'h10, 8'hC0, 8'hFF, 8'h00, 8'h77, 8'h99, 8'h3F, 8'h24, 8'hC6};

  initial begin
    logic [7:0] q [$];
    logic       mv0, mv1, en_m;
    logic [7:0] bexp;
    int         idx, got;

    reset_n = 1'b0;
    a_i_v = 1'b0; a_i_r = 1'b1; a_i_clr = 1'b0; a_i_d = '0;
    b_i_v = 1'b0; b_i_r = 1'b1; b_i_clr = 1'b0; b_i_d = '0;
    c_i_v = 1'b0; c_i_r = 1'b1; c_i_clr = 1'b0; c_i_d = '0;

    #2;
    chk("reset_a_o_v", 32'(a_o_v), 32'h0);
    chk("reset_a_o_d", 32'(a_o_d), 32'h0);
    chk("reset_a_o_s", 32'(a_o_s), 32'h0);
    chk("reset_a_o_r", 32'(a_o_r), 32'h1);
    chk("reset_b_o_v", 32'(b_o_v), 32'h0);
    chk("reset_c_o_v", 32'(c_o_v), 32'h0);

    @(negedge clk);
    reset_n = 1'b1;

    // Single transaction: lanes 5 and 12, two-cycle latency.
    @(negedge clk);
    a_i_d = '0;
    a_i_d[5*8 +: 8]  = 8'h01;
    a_i_d[12*8 +: 8] = 8'h80;
    a_i_v = 1'b1;
    @(negedge clk);
    a_i_v = 1'b0;
    chk("lat_cycle1_o_v", 32'(a_o_v), 32'h0);
    @(negedge clk);
    chk("lat_cycle2_o_v", 32'(a_o_v), 32'h1);
    chk("lat_cycle2_o_d", 32'(a_o_d), 32'h81);
    chk("lat_cycle2_o_s", 32'(a_o_s), 32'h0);
    @(negedge clk);
    chk("lat_sticky", 32'(a_o_s), 32'h81);
    chk("lat_bubble_o_v", 32'(a_o_v), 32'h0);

    // Back-to-back stream with i_r pattern 1,0,0,1.
    mv0 = 1'b0; mv1 = 1'b0; idx = 0; got = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      @(negedge clk);
      a_i_r = ((c % 4) == 0) || ((c % 4) == 3);
      if (idx < 10) begin
        a_i_v = 1'b1;
        a_i_d = '0;
        a_i_d[la[idx]*8 +: 8] = xa[idx];
        a_i_d[lb[idx]*8 +: 8] = xb[idx];
      end else begin
        a_i_v = 1'b0;
      end
      #1;
      en_m = !mv1 || a_i_r;
      chk("stream_o_v", 32'(a_o_v), 32'(mv1));
      chk("stream_o_r", 32'(a_o_r), 32'(en_m));
      if (mv1) begin
        chk("stream_o_d", 32'(a_o_d), 32'(q[0]));
        if (a_i_r) begin
          void'(q.pop_front());
          got++;
        end
      end
      if (en_m) begin
        mv1 = mv0;
        mv0 = a_i_v;
        if (a_i_v) begin
          q.push_back(ex[idx]);
          idx++;
        end
      end
    end
    chk("stream_delivered", 32'(got), 32'd10);
    a_i_v = 1'b0;
    a_i_r = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Sticky accumulator.
    a_i_clr = 1'b1;
    @(negedge clk);
    a_i_clr = 1'b0;
    chk("sticky_clear_base", 32'(a_o_s), 32'h0);
    a_i_d = '0;
    a_i_d[0 +: 8] = 8'h01;
    a_i_v = 1'b1;
    @(negedge clk);
    a_i_d[0 +: 8] = 8'h10;
    @(negedge clk);
    a_i_v = 1'b0;
    @(negedge clk);
    chk("sticky_first", 32'(a_o_s), 32'h01);
    @(negedge clk);
    chk("sticky_accum", 32'(a_o_s), 32'h11);
    a_i_d[0 +: 8] = 8'h04;
    a_i_v = 1'b1;
    @(negedge clk);
    a_i_v = 1'b0;
    @(negedge clk);
    chk("sticky_clr_dlv_o_v", 32'(a_o_v), 32'h1);
    chk("sticky_clr_dlv_o_d", 32'(a_o_d), 32'h04);
    a_i_clr = 1'b1;
    @(negedge clk);
    chk("sticky_clr_with_dlv", 32'(a_o_s), 32'h04);
    chk("sticky_clr_alone_o_v", 32'(a_o_v), 32'h0);
    @(negedge clk);
    a_i_clr = 1'b0;
    chk("sticky_clr_alone", 32'(a_o_s), 32'h00);

    // Walking one across all 40 input bits of the 5-lane radix-2 tree (three stages).
    for (int c = 0; c < 43; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        bexp = 8'h80 >> ((c - 3) % 8);
        chk("walk_o_v", 32'(b_o_v), 32'h1);
        chk("walk_o_d", 32'(b_o_d), 32'(bexp));
      end
      b_i_d = '0;
      if (c < 40) begin
        b_i_d[c] = 1'b1;
        b_i_v = 1'b1;
      end else begin
        b_i_v = 1'b0;
      end
    end
    @(negedge clk);
    chk("walk_drained_o_v", 32'(b_o_v), 32'h0);

    // Single lane acts as one register stage.
    c_i_d = 4'hA;
    c_i_v = 1'b1;
    @(negedge clk);
    c_i_v = 1'b0;
    chk("one_way_o_v", 32'(c_o_v), 32'h1);
    chk("one_way_o_d", 32'(c_o_d), 32'hA);
    @(negedge clk);
    chk("one_way_bubble", 32'(c_o_v), 32'h0);
    chk("one_way_sticky", 32'(c_o_s), 32'hA);

    // Mid-stream asynchronous reset.
    a_i_d = '0;
    a_i_d[3*8 +: 8] = 8'hFF;
    a_i_v = 1'b1;
    @(negedge clk);
    a_i_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_sticky", 32'(a_o_s), 32'hFF);
    a_i_d = '0;
    a_i_d[0 +: 8] = 8'h3C;
    a_i_v = 1'b1;
    @(negedge clk);
    a_i_d[0 +: 8] = 8'h5A;
    @(negedge clk);
    a_i_v = 1'b0;
    a_i_r = 1'b0;
    #1;
    chk("rst_pre_o_v", 32'(a_o_v), 32'h1);
    chk("rst_pre_o_d", 32'(a_o_d), 32'h3C);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_async_o_v", 32'(a_o_v), 32'h0);
    chk("rst_async_o_d", 32'(a_o_d), 32'h0);
    chk("rst_async_o_s", 32'(a_o_s), 32'h0);
    chk("rst_async_o_r", 32'(a_o_r), 32'h1);
    a_i_r = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_stale_o_v", 32'(a_o_v), 32'h0);
      chk("rst_no_stale_o_r", 32'(a_o_r), 32'h1);
    end
    chk("rst_post_o_s", 32'(a_o_s), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
